// File: rtl/dct_1d_mac_engine.sv
// dct_1d_mac_engine
//   N-point 1-D DCT/IDCT engine: y = C*x (mode 0) or y = C^T*x (mode 1).
//   The coefficient matrix is loadable at run time. LANES MACs are time-multiplexed
//   over N/LANES passes of N cycles each.
//   Optional feature macro: DCT_SAT_EN. When it is defined, results clamp to the
//   DATA_WIDTH signed range. When it is undefined, results wrap in two's complement.
module dct_1d_mac_engine #(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 14,
    parameter int LANES       = 2,
    localparam int AW         = $clog2(N * N)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode_sel,
    input  logic [N*DATA_WIDTH-1:0]   x_vec,
    input  logic                      coeff_we,
    input  logic [AW-1:0]             coeff_addr,
    input  logic [COEFF_WIDTH-1:0]    coeff_wdata,
    output logic                      coeff_err,
    output logic [N*DATA_WIDTH-1:0]   y_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int NW     = $clog2(N);
    localparam int ACC_W  = PROD_W + NW;
    localparam int SUM_W  = ACC_W + 1;
    localparam int PASSES = N / LANES;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(64'sd1 <<< (COEFF_FRAC - 1));
`ifdef DCT_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (DATA_WIDTH - 1)));
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic                           in_ready_q, in_ready_d;
    logic                           out_valid_q, out_valid_d;
    logic                           busy_q, busy_d;
    logic                           coeff_err_q, coeff_err_d;
    logic                           flush_q, flush_d;
    logic                           mode_q, mode_d;
    logic [NW-1:0]                  n_q, n_d;
    logic [PW-1:0]                  pass_q, pass_d;
    logic signed [DATA_WIDTH-1:0]   x_q [N];
    logic signed [DATA_WIDTH-1:0]   x_d [N];
    logic signed [COEFF_WIDTH-1:0]  coeff_q [N*N];
    logic signed [COEFF_WIDTH-1:0]  coeff_d [N*N];
    logic signed [ACC_W-1:0]        acc_q [LANES];
    logic signed [ACC_W-1:0]        acc_d [LANES];
    logic signed [DATA_WIDTH-1:0]   y_q [N];
    logic signed [DATA_WIDTH-1:0]   y_d [N];

    logic signed [PROD_W-1:0]       lane_prod [LANES];
    logic                           y_we;
    logic [PW-1:0]                  wr_pass;

    // Round half up, then arithmetic shift out the fraction, then reduce to DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [SUM_W-1:0] s;
        s = {a[ACC_W-1], a} + ROUND;
        s = s >>> COEFF_FRAC;
`ifdef DCT_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end
        return s[DATA_WIDTH-1:0];
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

    genvar gi;

    // Each lane works on output k = pass*LANES + lane. It reads C[k][n] or C[n][k].
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AW-1:0] c_idx;

            // Select the coefficient address for this lane in row-major order.
            always_comb begin
                if (mode_q) begin
                    c_idx = AW'(int'(n_q) * N + int'(pass_q) * LANES + gi);
                end else begin
                    c_idx = AW'((int'(pass_q) * LANES + gi) * N + int'(n_q));
                end
            end

            assign lane_prod[gi] = PROD_W'(x_q[n_q]) * PROD_W'(coeff_q[c_idx]);
        end

        for (gi = 0; gi < N; gi++) begin : g_yout
            assign y_vec[gi*DATA_WIDTH +: DATA_WIDTH] = y_q[gi];
        end
    endgenerate

    // Next-state logic covers the FSM, the MAC accumulation, result writeback and coefficient writes.
    // The accumulators of one pass are converted to results on the first cycle of the next pass.
    // A final flush cycle converts the last pass.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        coeff_err_d = 1'b0;
        flush_d     = flush_q;
        mode_d      = mode_q;
        n_d         = n_q;
        pass_d      = pass_q;
        x_d         = x_q;
        coeff_d     = coeff_q;
        acc_d       = acc_q;
        y_d         = y_q;
        y_we        = 1'b0;
        wr_pass     = pass_q;

        // Coefficient updates are only allowed while no block is being computed.
        if (coeff_we) begin
            if (state_q == S_COMPUTE) begin
                coeff_err_d = 1'b1;
            end else begin
                coeff_d[coeff_addr] = coeff_wdata;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        x_d[i] = x_vec[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    mode_d     = mode_sel;
                    n_d        = '0;
                    pass_d     = '0;
                    flush_d    = 1'b0;
                    state_d    = S_COMPUTE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            S_COMPUTE: begin
                if (flush_q) begin
                    y_we        = 1'b1;
                    wr_pass     = pass_q;
                    flush_d     = 1'b0;
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        if (n_q == '0) begin
                            acc_d[l] = ACC_W'(lane_prod[l]);
                        end else begin
                            acc_d[l] = acc_q[l] + ACC_W'(lane_prod[l]);
                        end
                    end
                    if ((n_q == '0) && (pass_q != '0)) begin
                        y_we    = 1'b1;
                        wr_pass = pass_q - PW'(1);
                    end
                    if (n_q == NW'(N - 1)) begin
                        n_d = '0;
                        if (pass_q == PW'(PASSES - 1)) begin
                            flush_d = 1'b1;
                        end else begin
                            pass_d = pass_q + PW'(1);
                        end
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase

        if (y_we) begin
            for (int l = 0; l < LANES; l++) begin
                y_d[NW'(int'(wr_pass) * LANES + l)] = round_sat(acc_q[l]);
            end
        end
    end

    // State and registered outputs. Reset discards any block in flight and clears the matrix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            coeff_err_q <= 1'b0;
            flush_q     <= 1'b0;
            mode_q      <= 1'b0;
            n_q         <= '0;
            pass_q      <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int i = 0; i < N * N; i++) begin
                coeff_q[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            coeff_err_q <= coeff_err_d;
            flush_q     <= flush_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            pass_q      <= pass_d;
            x_q         <= x_d;
            y_q         <= y_d;
            coeff_q     <= coeff_d;
            acc_q       <= acc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign coeff_err = coeff_err_q;

endmodule

// File: tb/tb_dct_1d_mac_engine.sv
// tb_dct_1d_mac_engine
//   Directed bench for dct_1d_mac_engine at default parameters. Expected results come
//   from a reference matrix model and pass through a scoreboard queue.
module tb_dct_1d_mac_engine;

    localparam int N   = 8;
    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int CF  = 14;
    localparam int VW  = N * DW;
    localparam int LAT = 33;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic            mode_sel;
    logic [VW-1:0]   x_vec;
    logic            coeff_we;
    logic [5:0]      coeff_addr;
    logic [CW-1:0]   coeff_wdata;
    logic            coeff_err;
    logic [VW-1:0]   y_vec;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              acc_cyc = 0;
    longint          coef_m [N*N];
    logic [VW-1:0]   sb [$];

    dct_1d_mac_engine #(
        .N(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRAC(CF), .LANES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode_sel(mode_sel), .x_vec(x_vec), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
        .coeff_wdata(coeff_wdata), .coeff_err(coeff_err), .y_vec(y_vec),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] model(input logic [VW-1:0] xv, input logic m);
        logic [VW-1:0] r;
        logic [DW-1:0] sl;
        longint acc, q, xs, cs;
        r = '0;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int n = 0; n < N; n++) begin
                xs = longint'($signed(xv[n*DW +: DW]));
                cs = m ? coef_m[n*N+k] : coef_m[k*N+n];
                acc += xs * cs;
            end
            q = (acc + (longint'(1) <<< (CF - 1))) >>> CF;
`ifdef DCT_SAT_EN
            if (q > ((longint'(1) <<< (DW - 1)) - 1)) q = (longint'(1) <<< (DW - 1)) - 1;
            else if (q < -(longint'(1) <<< (DW - 1))) q = -(longint'(1) <<< (DW - 1));
`endif
            sl = q[DW-1:0];
            r[k*DW +: DW] = sl;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int addr, input int val, input bit upd);
        coeff_we    = 1'b1;
        coeff_addr  = 6'(addr);
        coeff_wdata = 16'(val);
        tick();
        coeff_we = 1'b0;
        if (upd) coef_m[addr] = longint'(val);
    endtask

    task automatic send(input logic [VW-1:0] xv, input logic m);
        int w;
        w = 0;
        in_valid = 1'b1;
        x_vec    = xv;
        mode_sel = m;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", VW'(in_ready), VW'(1));
        tick();
        in_valid = 1'b0;
        x_vec    = '1;
        mode_sel = ~m;
        sb.push_back(model(xv, m));
        acc_cyc = cyc;
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 200) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, VW'(out_valid), VW'(1));
    endtask

    task automatic receive(input string tag);
        logic [VW-1:0] exp;
        out_ready = 1'b1;
        wait_valid(tag);
        check({tag, "_latency"}, VW'(cyc - acc_cyc), VW'(LAT));
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check(tag, y_vec, exp);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] xv;
        logic [VW-1:0] expb;
        logic [DW-1:0] y0_exp;
        bit            seen;

        for (int i = 0; i < N * N; i++) coef_m[i] = 0;
        reset_n = 1'b0; in_valid = 1'b0; mode_sel = 1'b0; x_vec = '0;
        coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ready", VW'(in_ready), VW'(1));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_coeff_err", VW'(coeff_err), VW'(0));
        check("rst_y_vec", y_vec, '0);

        // 1 Identity, forward
        for (int k = 0; k < N; k++) wr_coef(k * N + k, 16384, 1);
        check("idle_write_no_err", VW'(coeff_err), VW'(0));
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = DW'((i + 1) * 10);
        send(xv, 1'b0);
        check("compute_busy_ready", VW'({busy, in_ready}), VW'(2'b10));
        receive("identity");

        // 2 Transpose: only C[0][1] nonzero
        for (int k = 0; k < N; k++) wr_coef(k * N + k, 0, 1);
        wr_coef(1, 16384, 1);
        xv = '0;
        xv[0*DW +: DW] = DW'(100);
        xv[1*DW +: DW] = DW'(7);
        send(xv, 1'b0);
        receive("transpose_fwd");
        send(xv, 1'b1);
        receive("transpose_inv");

        // 3 Backpressure, with a half-weight coefficient to exercise rounding
        wr_coef(1, 0, 1);
        for (int k = 0; k < N; k++) wr_coef(k * N + k, 16384, 1);
        wr_coef(1 * N + 1, 8192, 1);
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = DW'(i * 37 - 100);
        xv[1*DW +: DW] = DW'(5);
        send(xv, 1'b0);
        out_ready = 1'b0;
        wait_valid("bp");
        expb = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_y", y_vec, expb);
            check("bp_hold_flags", VW'({out_valid, in_ready}), VW'(2'b10));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", VW'({out_valid, in_ready}), VW'(2'b01));
        xv[1*DW +: DW] = DW'(-7);
        xv[6*DW +: DW] = DW'(-32768);
        send(xv, 1'b0);
        receive("bp_second");

        // 4 Overflow on row 0
        for (int n = 0; n < N; n++) wr_coef(n, 16384, 1);
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = DW'(30000);
        send(xv, 1'b0);
        receive("overflow");
`ifdef DCT_SAT_EN
        y0_exp = 16'h7FFF;
`else
        y0_exp = 16'hA980;
`endif
        check("overflow_y0_const", VW'(y_vec[DW-1:0]), VW'(y0_exp));

        // 5 Coefficient write while busy is rejected
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = DW'(100 + i);
        send(xv, 1'b1);
        repeat (3) tick();
        wr_coef(0, 0, 0);
        check("busy_write_err_pulse", VW'(coeff_err), VW'(1));
        tick();
        check("busy_write_err_clear", VW'(coeff_err), VW'(0));
        receive("busy_write_result");
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = DW'(100);
        send(xv, 1'b0);
        receive("busy_write_matrix_kept");

        // 6 Reset in the middle of a block
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = DW'(1000 - i * 300);
        send(xv, 1'b0);
        repeat (9) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_flags", VW'({out_valid, busy, in_ready}), VW'(3'b001));
        tick();
        tick();
        reset_n = 1'b1;
        sb.delete();
        for (int i = 0; i < N * N; i++) coef_m[i] = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("midrst_no_output", VW'(seen), VW'(0));
        check("midrst_in_ready", VW'(in_ready), VW'(1));
        send(xv, 1'b0);
        receive("midrst_zero_coeffs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
